video_sync_tracker: RTL

Receive-side counterpart of the display timing generator. Accepts the active-low hsync/vsync pair produced by a timing source on the same pixel clock, measures line length and frame height, and locks onto the stream. Once locked, it regenerates scan position counters that track the source. It sits at the video input of the design, for loopback self-check and for downstream blocks that need position recovered from sync pulses alone.

---
 rtl/video_sync_tracker.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/video_sync_tracker.sv
// video_sync_tracker: recovers scan position from an active-low hsync/vsync pair.
// Measures line length and frame height over one full frame, locks when the frame
// is consistent, then regenerates h_pos/v_pos one cycle behind the source and flags
// any departure from the locked geometry with a single-cycle sync_error pulse.
module video_sync_tracker #(
  parameter int unsigned HCOUNT_WIDTH = 10,
  parameter int unsigned VCOUNT_WIDTH = 10,
  parameter int unsigned H_MIN        = 16,
  parameter int unsigned V_MIN        = 4
) (
  input  logic                    clk,
  input  logic                    _reset,
  input  logic                    hsync,
  input  logic                    vsync,
  output logic [HCOUNT_WIDTH-1:0] h_pos,
  output logic [VCOUNT_WIDTH-1:0] v_pos,
  output logic                    locked,
  output logic [HCOUNT_WIDTH-1:0] h_max,
  output logic [VCOUNT_WIDTH-1:0] v_max,
  output logic                    sync_error
);

  localparam logic [HCOUNT_WIDTH-1:0] HMin = HCOUNT_WIDTH'(H_MIN);
  localparam logic [VCOUNT_WIDTH-1:0] VMin = VCOUNT_WIDTH'(V_MIN);

  typedef enum logic [1:0] {
    StSearch,
    StMeasure,
    StLocked
  } state_e;

  state_e                  state_q, state_d;
  logic                    hs_q, vs_q;
  logic [HCOUNT_WIDTH-1:0] h_pos_q, h_pos_d;
  logic [VCOUNT_WIDTH-1:0] v_pos_q, v_pos_d;
  logic [HCOUNT_WIDTH-1:0] h_meas_q, h_meas_d;
  logic                    meas_valid_q, meas_valid_d;
  logic                    mismatch_q, mismatch_d;
  logic [HCOUNT_WIDTH-1:0] h_max_q, h_max_d;
  logic [VCOUNT_WIDTH-1:0] v_max_q, v_max_d;
  logic                    sync_error_q, sync_error_d;

  // Edge detection and derived events, all combinational on the live inputs.
  logic                    hs_fall, vs_fall, frame_ev, vs_only;
  logic                    h_sat, v_sat, h_overrun;
  logic                    line_bad, frame_ok, lock_err;
  logic [HCOUNT_WIDTH-1:0] frame_h;

  assign hs_fall  = ~hsync & hs_q;
  assign vs_fall  = ~vsync & vs_q;
  assign frame_ev = hs_fall & vs_fall;
  // A vsync edge not aligned with an hsync edge is a framing violation.
  assign vs_only  = vs_fall & ~hs_fall;
  assign h_sat    = &h_pos_q;
  assign v_sat    = &v_pos_q;
  // Saturation only counts when no hsync edge clears the counter this cycle.
  assign h_overrun = h_sat & ~hs_fall;

  // Length of the line ending now disagrees with the first measured line.
  assign line_bad = meas_valid_q & (h_pos_q != h_meas_q);
  // Line length for this frame; if nothing was stored yet, the ending line is it.
  assign frame_h  = meas_valid_q ? h_meas_q : h_pos_q;
  assign frame_ok = ~mismatch_q & ~line_bad & (frame_h >= HMin) & (v_pos_q >= VMin);

  // Any departure from the locked geometry; the second term catches a missing hsync
  // on the cycle the counter would step past h_max.
  assign lock_err = (hs_fall & (h_pos_q != h_max_q))
                  | (~hs_fall & (h_pos_q == h_max_q))
                  | (frame_ev & (v_pos_q != v_max_q))
                  | (hs_fall & ~vs_fall & (v_pos_q == v_max_q))
                  | vs_only;

  // Sync edge history; reset high so a low level at release reads as an edge.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      hs_q <= hsync;
      vs_q <= vsync;
    end
  end

  // Scan position counters run in every state and saturate instead of wrapping.
  always_comb begin
    h_pos_d = h_pos_q;
    v_pos_d = v_pos_q;
    if (hs_fall) begin
      h_pos_d = '0;
    end else if (!h_sat) begin
      h_pos_d = h_pos_q + HCOUNT_WIDTH'(1);
    end
    if (frame_ev) begin
      v_pos_d = '0;
    end else if (hs_fall && !v_sat) begin
      v_pos_d = v_pos_q + VCOUNT_WIDTH'(1);
    end
  end

  // Position counter registers.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      h_pos_q <= '0;
      v_pos_q <= '0;
    end else begin
      h_pos_q <= h_pos_d;
      v_pos_q <= v_pos_d;
    end
  end

  // Lock FSM next-state: search for a frame start, measure one frame, then track.
  always_comb begin
    state_d      = state_q;
    h_meas_d     = h_meas_q;
    meas_valid_d = meas_valid_q;
    mismatch_d   = mismatch_q;
    h_max_d      = h_max_q;
    v_max_d      = v_max_q;
    sync_error_d = 1'b0;

    unique case (state_q)
      StSearch: begin
        if (frame_ev) begin
          state_d      = StMeasure;
          meas_valid_d = 1'b0;
          mismatch_d   = 1'b0;
        end
      end

      StMeasure: begin
        if (vs_only || h_overrun) begin
          state_d = StSearch;
        end else if (frame_ev) begin
          if (frame_ok) begin
            h_max_d = frame_h;
            v_max_d = v_pos_q;
            state_d = StLocked;
          end else begin
            // Bad frame: this event becomes the start of the next measurement.
            meas_valid_d = 1'b0;
            mismatch_d   = 1'b0;
          end
        end else if (hs_fall) begin
          if (!meas_valid_q) begin
            h_meas_d     = h_pos_q;
            meas_valid_d = 1'b1;
          end else if (line_bad) begin
            mismatch_d = 1'b1;
          end
        end
      end

      StLocked: begin
        if (lock_err) begin
          state_d      = StSearch;
          sync_error_d = 1'b1;
        end
      end

      default: begin
        state_d = StSearch;
      end
    endcase
  end

  // Lock FSM state, measurement scratch and locked geometry registers.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q      <= StSearch;
      h_meas_q     <= '0;
      meas_valid_q <= 1'b0;
      mismatch_q   <= 1'b0;
      h_max_q      <= '0;
      v_max_q      <= '0;
      sync_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_meas_q     <= h_meas_d;
      meas_valid_q <= meas_valid_d;
      mismatch_q   <= mismatch_d;
      h_max_q      <= h_max_d;
      v_max_q      <= v_max_d;
      sync_error_q <= sync_error_d;
    end
  end

  assign h_pos      = h_pos_q;
  assign v_pos      = v_pos_q;
  assign locked     = (state_q == StLocked);
  assign h_max      = h_max_q;
  assign v_max      = v_max_q;
  assign sync_error = sync_error_q;

endmodule
